result_tx_sequencer: RTL and testbench



---
 rtl/result_tx_sequencer.sv | 127 ++++++++++++
 tb/tb_result_tx_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx_sequencer.sv
// Streams a zero-padded result buffer to a UART TX byte by byte: leading/embedded 0x00 skipped, stops at 0x0D (+ optional 0x0A).
// First tx_start 3 cycles after out_en rises; each byte waits for tx_ready to drop (accepted) and rise again (finished).
module result_tx_sequencer #(
    parameter int MAX_BYTES = 16,
    parameter bit APPEND_LF = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   out_en,
    input  logic [8*MAX_BYTES-1:0] out_buf,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic                   sent,
    output logic                   busy
);
    localparam int               IDX_W   = $clog2(MAX_BYTES + 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(MAX_BYTES);
    localparam logic [7:0]       CR      = 8'h0D;
    localparam logic [7:0]       LF      = 8'h0A;

    typedef enum logic [2:0] {
        IDLE, LOAD, SCAN, WAIT_ACK, WAIT_DONE, SEND_LF, DONE
    } state_t;

    state_t                 state_q;
    logic [8*MAX_BYTES-1:0] shift_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   lf_pending_q;
    logic                   out_en_dly_q;
    logic [7:0]             tx_data_q;
    logic                   tx_start_q;
    logic                   sent_q;
    logic                   busy_q;

    logic                   start;
    logic [7:0]             cur_byte;

    assign start    = out_en & ~out_en_dly_q;
    // The byte under consideration is always the top of the shift register.
    assign cur_byte = shift_q[8*MAX_BYTES-1 -: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            lf_pending_q <= 1'b0;
            out_en_dly_q <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            sent_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            out_en_dly_q <= out_en;
            tx_start_q   <= 1'b0;
            sent_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    shift_q      <= out_buf;
                    idx_q        <= '0;
                    lf_pending_q <= 1'b0;
                    state_q      <= SCAN;
                end
                SCAN: begin
                    if (idx_q == IDX_END) begin
                        state_q <= DONE;
                        sent_q  <= 1'b1;
                    end else if (cur_byte == 8'h00) begin
                        shift_q <= shift_q << 8;
                        idx_q   <= idx_q + 1'b1;
                    end else if (tx_ready) begin
                        tx_data_q  <= cur_byte;
                        tx_start_q <= 1'b1;
                        state_q    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!tx_ready) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // cur_byte is not shifted out until its transmission finishes.
                    if (tx_ready) begin
                        if (lf_pending_q || (cur_byte == CR && !APPEND_LF)) begin
                            state_q <= DONE;
                            sent_q  <= 1'b1;
                        end else if (cur_byte == CR) begin
                            state_q <= SEND_LF;
                        end else begin
                            shift_q <= shift_q << 8;
                            idx_q   <= idx_q + 1'b1;
                            state_q <= SCAN;
                        end
                    end
                end
                SEND_LF: begin
                    if (tx_ready) begin
                        tx_data_q    <= LF;
                        tx_start_q   <= 1'b1;
                        lf_pending_q <= 1'b1;
                        state_q      <= WAIT_ACK;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign sent     = sent_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Bench for result_tx_sequencer: one instance with LF append, one without, each driven by an ideal UART model.
// Transmitted bytes are checked against a scoreboard filled from a reference walk of each buffer.
module tb_result_tx_sequencer;
    localparam int MB = 16;

    typedef struct {
        int           d;      // 0: APPEND_LF=1 instance, 1: APPEND_LF=0 instance
        logic [127:0] b;
        int           nb;     // expected number of tx_start pulses
        int           first;  // cycles from out_en high to first tx_start, -1 = not checked
        int           slat;   // cycles from out_en high to sent, -1 = not checked
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         out_en     [2];
    logic [127:0] out_buf    [2];
    logic         tx_ready_w [2];
    logic [7:0]   tx_data_w  [2];
    logic         tx_start_w [2];
    logic         sent_w     [2];
    logic         busy_w     [2];

    logic ready_r  [2];
    logic hold_low [2];
    logic acc_pend [2];
    int   busy_cnt [2];

    int n_start   [2];
    int n_sent    [2];
    int first_cyc [2];
    int sent_cyc  [2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    result_tx_sequencer #(.MAX_BYTES(MB), .APPEND_LF(1'b1)) dut_lf (
        .clk(clk), .rst_n(rst_n), .out_en(out_en[0]), .out_buf(out_buf[0]),
        .tx_ready(tx_ready_w[0]), .tx_data(tx_data_w[0]), .tx_start(tx_start_w[0]),
        .sent(sent_w[0]), .busy(busy_w[0])
    );

    result_tx_sequencer #(.MAX_BYTES(MB), .APPEND_LF(1'b0)) dut_nolf (
        .clk(clk), .rst_n(rst_n), .out_en(out_en[1]), .out_buf(out_buf[1]),
        .tx_ready(tx_ready_w[1]), .tx_data(tx_data_w[1]), .tx_start(tx_start_w[1]),
        .sent(sent_w[1]), .busy(busy_w[1])
    );

    assign tx_ready_w[0] = ready_r[0] & ~hold_low[0];
    assign tx_ready_w[1] = ready_r[1] & ~hold_low[1];

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_byte(input int d, input logic [7:0] c);
        if (d == 0) exp_q0.push_back(c);
        else        exp_q1.push_back(c);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Reference: nonzero bytes in order up to and including the first CR, LF only on instance 0.
    task automatic push_expected(input int d, input logic [127:0] b);
        logic [7:0] c;
        bit         stop;
        stop = 1'b0;
        for (int k = 0; k < MB; k++) begin
            c = b[8*(MB-1-k) +: 8];
            if (!stop && c != 8'h00) begin
                push_byte(d, c);
                if (c == 8'h0D) begin
                    if (d == 0) push_byte(d, 8'h0A);
                    stop = 1'b1;
                end
            end
        end
    endtask

    task automatic check_byte(input int d, input logic [7:0] got);
        logic [7:0] e;
        checks++;
        if (qsize(d) == 0) begin
            errors++;
            $display("FAIL tx_byte dut%0d got=%02h exp=none", d, got);
        end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL tx_byte dut%0d got=%02h exp=%02h", d, got, e);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_start_w[d] === 1'b1) begin
                n_start[d]++;
                if (first_cyc[d] < 0) first_cyc[d] = cyc;
                check_byte(d, tx_data_w[d]);
            end
            if (sent_w[d] === 1'b1) begin
                n_sent[d]++;
                sent_cyc[d] = cyc;
            end
        end
    end

    // Ideal UART: ready drops one cycle after a start pulse and returns 10 cycles later.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                if (acc_pend[d]) begin
                    acc_pend[d] = 1'b0;
                    ready_r[d]  = 1'b0;
                    busy_cnt[d] = 10;
                end else if (busy_cnt[d] > 0) begin
                    busy_cnt[d]--;
                    if (busy_cnt[d] == 0) ready_r[d] = 1'b1;
                end
                if (tx_start_w[d] === 1'b1) acc_pend[d] = 1'b1;
            end
        end
    end

    task automatic clear_counts(input int d);
        n_start[d]   = 0;
        n_sent[d]    = 0;
        first_cyc[d] = -1;
        sent_cyc[d]  = -1;
    endtask

    task automatic wait_sent(input int d, input string tag);
        for (int t = 0; t < 3000 && n_sent[d] == 0; t++) @(posedge clk);
        #1;
        check({tag, "_sent_seen"}, (n_sent[d] > 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic run_case(input int d, input logic [127:0] b, input int nb,
                            input int first, input int slat, input string tag);
        int k;
        clear_counts(d);
        push_expected(d, b);
        @(posedge clk); #1;
        out_buf[d] = b;
        out_en[d]  = 1'b1;
        k          = cyc;
        repeat (2) @(posedge clk); #1;
        check({tag, "_busy_hi"}, busy_w[d], 1);
        wait_sent(d, tag);
        @(posedge clk); #1;
        out_en[d] = 1'b0;
        repeat (3) @(posedge clk); #1;
        check({tag, "_busy_lo"}, busy_w[d], 0);
        check({tag, "_n_sent"}, n_sent[d], 1);
        check({tag, "_n_bytes"}, n_start[d], nb);
        check({tag, "_q_empty"}, qsize(d), 0);
        if (first >= 0) check({tag, "_first_lat"}, first_cyc[d] - k, first);
        if (slat >= 0)  check({tag, "_sent_lat"}, sent_cyc[d] - k, slat);
    endtask

    initial begin
        vec_t         vecs [9];
        logic [127:0] hb;
        logic [127:0] rb;
        int           r;

        vecs[0] = '{0, {104'h0, 24'h34320D}, 4, 16, -1};
        vecs[1] = '{1, {24'h370D39, 104'h0}, 2, 3, -1};
        // 1 cycle to register out_en, then MAX_BYTES+2 to DONE.
        vecs[2] = '{0, 128'h0, 0, -1, 19};
        vecs[3] = '{0, {16{8'h31}}, 16, 3, -1};
        vecs[4] = '{1, {16{8'h31}}, 16, 3, -1};
        vecs[5] = '{0, {40'h3100320D33, 88'h0}, 4, 3, -1};
        vecs[6] = '{1, {120'h0, 8'h0D}, 1, 18, -1};
        vecs[7] = '{0, {120'h0, 8'h0D}, 2, 18, -1};
        vecs[8] = '{1, 128'h0, 0, -1, 19};

        for (int d = 0; d < 2; d++) begin
            out_en[d]   = 1'b0;
            out_buf[d]  = '0;
            ready_r[d]  = 1'b1;
            hold_low[d] = 1'b0;
            acc_pend[d] = 1'b0;
            busy_cnt[d] = 0;
            clear_counts(d);
        end

        repeat (3) @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_tx_data%0d", d), tx_data_w[d], 0);
            check($sformatf("reset_tx_start%0d", d), tx_start_w[d], 0);
            check($sformatf("reset_sent%0d", d), sent_w[d], 0);
            check($sformatf("reset_busy%0d", d), busy_w[d], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++)
            run_case(vecs[i].d, vecs[i].b, vecs[i].nb, vecs[i].first, vecs[i].slat,
                     $sformatf("vec%0d", i));

        // UART not ready at start, then out_en held high well after sent.
        hb = {16'h350D, 112'h0};
        clear_counts(0);
        push_expected(0, hb);
        hold_low[0] = 1'b1;
        @(posedge clk); #1;
        out_buf[0] = hb;
        out_en[0]  = 1'b1;
        repeat (20) @(posedge clk); #1;
        check("hold_no_start", n_start[0], 0);
        check("hold_busy", busy_w[0], 1);
        hold_low[0] = 1'b0;
        r = cyc;
        wait_sent(0, "hold");
        check("hold_first_after_ready", first_cyc[0] - r, 1);
        check("hold_n_bytes", n_start[0], 3);
        repeat (50) @(posedge clk); #1;
        check("level_no_retrigger_sent", n_sent[0], 1);
        check("level_no_retrigger_start", n_start[0], 3);
        check("level_idle", busy_w[0], 0);
        check("hold_q_empty", qsize(0), 0);
        out_en[0] = 1'b0;
        repeat (3) @(posedge clk);

        // Reset while the second byte is still being transmitted.
        rb = {32'h3132330D, 96'h0};
        clear_counts(0);
        push_expected(0, rb);
        @(posedge clk); #1;
        out_buf[0] = rb;
        out_en[0]  = 1'b1;
        for (int t = 0; t < 2000 && n_start[0] < 2; t++) @(posedge clk);
        check("rst_reached_byte2", n_start[0], 2);
        repeat (3) @(posedge clk); #3;
        check("rst_pre_busy", busy_w[0], 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx_start", tx_start_w[0], 0);
        check("rst_async_tx_data", tx_data_w[0], 0);
        check("rst_async_sent", sent_w[0], 0);
        check("rst_async_busy", busy_w[0], 0);
        out_en[0]   = 1'b0;
        exp_q0.delete();
        acc_pend[0] = 1'b0;
        busy_cnt[0] = 0;
        ready_r[0]  = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("rst_no_sent", n_sent[0], 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_case(0, rb, 5, 3, -1, "rst_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
